// File: rtl/sram_ahb_pkg.sv
// Shared AHB-Lite encodings, FSM states and burst helpers for the SRAM burst master.
package sram_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] SIZE_W = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR  = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    // incr_len is the already-clamped length used only for undefined-length INCR
    function automatic logic [4:0] burst_beats(input logic [2:0] burst, input logic [4:0] incr_len);
        logic [4:0] beats;
        case (burst)
            HBURST_SINGLE:                beats = 5'd1;
            HBURST_INCR:                  beats = incr_len;
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                      beats = 5'd1;
        endcase
        return beats;
    endfunction

    // All incrementing burst encodings are odd
    function automatic logic burst_is_incr(input logic [2:0] burst);
        return burst[0];
    endfunction

endpackage

// File: rtl/sram_ahb_burst_master_if.sv
// AHB-Lite bus bundle between the burst master and the SRAM controller slave port.
interface sram_ahb_burst_master_if;

    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hburst, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hburst, hwdata,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/sram_ahb_addr_gen.sv
// Next word address for a burst: plain +4 for INCR types, low-bit wrap for WRAPn.
module sram_ahb_addr_gen
    import sram_ahb_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [2:0]  burst_i,
    output logic [31:0] addr_next_o
);

    logic [31:0] inc_s;
    logic [31:0] wrap_mask_s;

    // Only the masked bits take the incremented value; the rest stay put so WRAP bursts wrap
    always_comb begin
        inc_s = addr_i + 32'd4;
        case (burst_i)
            HBURST_WRAP4:  wrap_mask_s = 32'h0000_000C;
            HBURST_WRAP8:  wrap_mask_s = 32'h0000_001C;
            HBURST_WRAP16: wrap_mask_s = 32'h0000_003C;
            default:       wrap_mask_s = 32'hFFFF_FFFF;
        endcase
        addr_next_o = (addr_i & ~wrap_mask_s) | (inc_s & wrap_mask_s);
    end

endmodule

// File: rtl/sram_ahb_burst_master.sv
// AHB-Lite burst initiator: one client command at a time, word transfers with BUSY
// insertion on write underrun, wait-state hold, and two-cycle ERROR recovery.
module sram_ahb_burst_master
    import sram_ahb_pkg::*;
#(
    parameter int ADDR_WIN_BITS = 14,
    parameter int MAX_INCR_LEN  = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_burst,
    input  logic [4:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        done_err,
    sram_ahb_burst_master_if.master ahb
);

    localparam logic [4:0] MAX_LEN_C = 5'(MAX_INCR_LEN);
    localparam int         LIDX_W    = ADDR_WIN_BITS - 1;

    state_e      state_q,  state_d;
    logic [31:0] haddr_q,  haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hburst_q, hburst_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q,  rd_data_d;
    logic [4:0]  beats_q,  beats_d;
    logic [4:0]  beat_q,   beat_d;
    logic        dphase_q, dphase_d;
    logic        err_q,    err_d;
    logic        rej_q,    rej_d;

    logic [4:0]        cmd_len_s;
    logic [4:0]        cmd_beats_s;
    logic [LIDX_W-1:0] last_idx_s;
    logic              reject_s;
    logic              err_now_s;
    logic [1:0]        htrans_s;
    logic [31:0]       addr_next_s;

    sram_ahb_addr_gen u_addr_gen (
        .addr_i      (haddr_q),
        .burst_i     (hburst_q),
        .addr_next_o (addr_next_s)
    );

    // Command decode: clamp INCR length, beat count, and window overflow of the final beat
    always_comb begin
        if (cmd_len == 5'd0) begin
            cmd_len_s = 5'd1;
        end else if (cmd_len > MAX_LEN_C) begin
            cmd_len_s = MAX_LEN_C;
        end else begin
            cmd_len_s = cmd_len;
        end
        cmd_beats_s = burst_beats(cmd_burst, cmd_len_s);
        last_idx_s  = {1'b0, cmd_addr[ADDR_WIN_BITS-1:2]} + LIDX_W'(cmd_beats_s) - LIDX_W'(1);
        reject_s    = burst_is_incr(cmd_burst) & last_idx_s[LIDX_W-1];
    end

    // Transfer type; a first-cycle ERROR on a pending data phase cancels the address phase at once
    always_comb begin
        err_now_s = dphase_q & ahb.hresp & ~ahb.hready;
        htrans_s  = HTRANS_IDLE;
        if ((state_q == ST_ADDR) && !err_now_s) begin
            if (!hwrite_q || wr_valid) begin
                htrans_s = (beat_q == 5'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            end else begin
                htrans_s = (beat_q == 5'd0) ? HTRANS_IDLE : HTRANS_BUSY;
            end
        end else begin
            htrans_s = HTRANS_IDLE;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        beats_d    = beats_q;
        beat_d     = beat_q;
        dphase_d   = dphase_q;
        err_d      = err_q;
        rej_d      = rej_q;
        rd_valid_d = dphase_q & ahb.hready & ~ahb.hresp & ~hwrite_q &
                     ((state_q == ST_ADDR) || (state_q == ST_LAST));
        rd_data_d  = rd_valid_d ? ahb.hrdata : rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    beat_d   = 5'd0;
                    dphase_d = 1'b0;
                    err_d    = 1'b0;
                    rej_d    = reject_s;
                    if (reject_s) begin
                        // Rejects spend one cycle in ERR so done trails acceptance by two cycles
                        state_d = ST_ERR;
                    end else begin
                        state_d  = ST_ADDR;
                        haddr_d  = cmd_addr & 32'hFFFF_FFFC;
                        hwrite_d = cmd_write;
                        hburst_d = cmd_burst;
                        beats_d  = cmd_beats_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (err_now_s) begin
                    state_d  = ST_ERR;
                    dphase_d = 1'b0;
                end else if (ahb.hready) begin
                    dphase_d = htrans_s[1];
                    if (htrans_s[1]) begin
                        hwdata_d = hwrite_q ? wr_data : hwdata_q;
                        if (beat_q == (beats_q - 5'd1)) begin
                            state_d = ST_LAST;
                        end else begin
                            beat_d  = beat_q + 5'd1;
                            haddr_d = addr_next_s;
                        end
                    end else begin
                        hwdata_d = hwdata_q;
                    end
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_LAST: begin
                if (err_now_s) begin
                    state_d  = ST_ERR;
                    dphase_d = 1'b0;
                end else if (ahb.hready) begin
                    state_d  = ST_FIN;
                    dphase_d = 1'b0;
                end else begin
                    state_d = ST_LAST;
                end
            end
            ST_ERR: begin
                if (rej_q || (ahb.hresp && ahb.hready)) begin
                    state_d = ST_FIN;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            haddr_q    <= 32'd0;
            hwrite_q   <= 1'b0;
            hburst_q   <= HBURST_SINGLE;
            hwdata_q   <= 32'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
            beats_q    <= 5'd1;
            beat_q     <= 5'd0;
            dphase_q   <= 1'b0;
            err_q      <= 1'b0;
            rej_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hburst_q   <= hburst_d;
            hwdata_q   <= hwdata_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            beats_q    <= beats_d;
            beat_q     <= beat_d;
            dphase_q   <= dphase_d;
            err_q      <= err_d;
            rej_q      <= rej_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign wr_ready    = (state_q == ST_ADDR) & hwrite_q & ahb.hready & htrans_s[1];
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign done        = (state_q == ST_FIN);
    assign done_err    = (state_q == ST_FIN) & err_q;

    assign ahb.haddr   = haddr_q;
    assign ahb.htrans  = htrans_s;
    assign ahb.hwrite  = hwrite_q;
    assign ahb.hsize   = SIZE_W;
    assign ahb.hburst  = hburst_q;
    assign ahb.hwdata  = hwdata_q;

endmodule

// File: tb/tb_sram_ahb_burst_master.sv
// Directed bench for sram_ahb_burst_master: scripted slave wait/error timing, per-cycle trace.
module tb_sram_ahb_burst_master;
    import sram_ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [2:0]  cmd_burst = 3'd0;
    logic [4:0]  cmd_len = 5'd0;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        done_err;

    sram_ahb_burst_master_if bus ();

    sram_ahb_burst_master #(.ADDR_WIN_BITS(14), .MAX_INCR_LEN(16)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_burst (cmd_burst),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .done_err  (done_err),
        .ahb       (bus)
    );

    always #5 hclk = ~hclk;

    // Cycle bookkeeping; rel counts cycles from the command-accept cycle (rel 0)
    int   cyc = 0;
    int   t_acc = 0;
    int   rel;
    logic mon_on = 1'b0;
    logic wr_en = 1'b0;
    int   st_s = 1000, st_l = 0, er_s = 1000, bz_s = 1000, bz_l = 0;
    logic [31:0] dp_addr = 32'd0;

    always @(posedge hclk) cyc <= cyc + 1;
    assign rel = cyc - t_acc;

    // Scripted slave: stall window, two-cycle error, read data tagged with the data-phase address
    assign bus.hready = !(mon_on && ((rel >= st_s && rel < st_s + st_l) || rel == er_s));
    assign bus.hresp  = mon_on && (rel == er_s || rel == er_s + 1);
    always @(posedge hclk) if (bus.hready && bus.htrans[1]) dp_addr <= bus.haddr;
    assign bus.hrdata = {16'hA5A5, dp_addr[15:0]};

    // Write client: beat data tagged with its address, optional underrun window
    assign wr_valid = wr_en && !(rel >= bz_s && rel < bz_s + bz_l);
    assign wr_data  = {16'hC0DE, bus.haddr[15:0]};

    logic [1:0]  tr_log [0:47];
    logic [31:0] ad_log [0:47];
    logic [31:0] wd_log [0:47];
    logic        cr_log [0:47];
    logic [31:0] rd_log [0:15];
    int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_rel = -1, rd_rel = -1;
    logic        done_err_seen = 1'b0;

    // Trace monitor sampled on the falling edge
    always @(negedge hclk) begin
        if (mon_on && rel >= 0 && rel < 48) begin
            if (rel == 0) begin
                wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_rel = -1; rd_rel = -1;
                done_err_seen = 1'b0;
            end
            tr_log[rel] = bus.htrans;
            ad_log[rel] = bus.haddr;
            wd_log[rel] = bus.hwdata;
            cr_log[rel] = cmd_ready;
            if (wr_ready) wr_cnt = wr_cnt + 1;
            if (rd_valid) begin
                if (rd_cnt == 0) rd_rel = rel;
                if (rd_cnt < 16) rd_log[rd_cnt] = rd_data;
                rd_cnt = rd_cnt + 1;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_rel = rel;
                done_err_seen = done_err;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] burst,
                           input logic [4:0] len, input int s_s, input int s_l, input int e_s,
                           input int b_s, input int b_l);
        @(posedge hclk); #1;
        st_s = s_s; st_l = s_l; er_s = e_s; bz_s = b_s; bz_l = b_l; wr_en = wr;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_burst = burst; cmd_len = len;
        t_acc = cyc;
        mon_on = 1'b1;
        @(posedge hclk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && done_cnt == 0; i++) begin
            @(posedge hclk); #1;
        end
        repeat (2) @(posedge hclk);
        #1;
        mon_on = 1'b0;
        wr_en  = 1'b0;
        check_val("done_count", done_cnt, 1);
    endtask

    initial begin
        int dn;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check_val("rst_htrans",   bus.htrans, HTRANS_IDLE);
        check_val("rst_haddr",    bus.haddr, 32'd0);
        check_val("rst_hwrite",   bus.hwrite, 1'b0);
        check_val("rst_hburst",   bus.hburst, HBURST_SINGLE);
        check_val("rst_hwdata",   bus.hwdata, 32'd0);
        check_val("rst_hsize",    bus.hsize, 3'b010);
        check_val("rst_rd",       {rd_valid, done, done_err, wr_ready}, 4'b0000);
        check_val("rst_rd_data",  rd_data, 32'd0);
        check_val("rst_cmd_rdy",  cmd_ready, 1'b1);
        hreset = 1'b0;

        // SINGLE read at 0x100, zero wait
        run_cmd(1'b0, 32'h100, HBURST_SINGLE, 5'd0, 1000, 0, 1000, 1000, 0);
        check_val("t1_htrans",    tr_log[1], HTRANS_NONSEQ);
        check_val("t1_haddr",     ad_log[1], 32'h100);
        check_val("t1_rd_cnt",    rd_cnt, 1);
        check_val("t1_rd_data",   rd_log[0], 32'hA5A5_0100);
        check_val("t1_rd_rel",    rd_rel, 3);
        check_val("t1_done_rel",  done_rel, 3);
        check_val("t1_done_err",  done_err_seen, 1'b0);

        // WRAP4 write at 0x38
        run_cmd(1'b1, 32'h38, HBURST_WRAP4, 5'd0, 1000, 0, 1000, 1000, 0);
        begin
            logic [31:0] exp_a [0:3];
            exp_a[0] = 32'h38; exp_a[1] = 32'h3C; exp_a[2] = 32'h30; exp_a[3] = 32'h34;
            for (int i = 0; i < 4; i++) begin
                check_val("t2_haddr",  ad_log[1+i], exp_a[i]);
                check_val("t2_htrans", tr_log[1+i], (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
                check_val("t2_hwdata", wd_log[2+i], {16'hC0DE, exp_a[i][15:0]});
            end
        end
        check_val("t2_hburst",    bus.hburst, HBURST_WRAP4);
        check_val("t2_wr_cnt",    wr_cnt, 4);
        check_val("t2_done_rel",  done_rel, 6);

        // INCR8 write at 0 with two underrun cycles after beat 2
        run_cmd(1'b1, 32'h0, HBURST_INCR8, 5'd0, 1000, 0, 1000, 4, 2);
        check_val("t3_busy0",     tr_log[4], HTRANS_BUSY);
        check_val("t3_busy1",     tr_log[5], HTRANS_BUSY);
        check_val("t3_addr_hold", ad_log[5], 32'hC);
        check_val("t3_resume",    tr_log[6], HTRANS_SEQ);
        check_val("t3_resume_a",  ad_log[6], 32'hC);
        check_val("t3_last_a",    ad_log[10], 32'h1C);
        check_val("t3_idle_last", tr_log[11], HTRANS_IDLE);
        check_val("t3_wr_cnt",    wr_cnt, 8);
        check_val("t3_done_rel",  done_rel, 12);

        // INCR4 read at 0x40, beat 1 data phase stalled three cycles
        run_cmd(1'b0, 32'h40, HBURST_INCR4, 5'd0, 3, 3, 1000, 1000, 0);
        for (int r = 3; r < 6; r++) begin
            check_val("t4_hold_tr", tr_log[r], HTRANS_SEQ);
            check_val("t4_hold_a",  ad_log[r], 32'h48);
        end
        check_val("t4_rd_cnt",    rd_cnt, 4);
        for (int i = 0; i < 4; i++) check_val("t4_rd_data", rd_log[i], 32'hA5A5_0040 + 32'(4 * i));
        check_val("t4_done_rel",  done_rel, 9);

        // INCR16 read at 0x3FF0 overruns the 16KB window
        run_cmd(1'b0, 32'h3FF0, HBURST_INCR16, 5'd0, 1000, 0, 1000, 1000, 0);
        for (int r = 0; r < 4; r++) check_val("t5_no_bus", tr_log[r], HTRANS_IDLE);
        check_val("t5_done_rel",  done_rel, 2);
        check_val("t5_done_err",  done_err_seen, 1'b1);
        check_val("t5_cmd_rdy",   cr_log[2], 1'b0);
        check_val("t5_rd_cnt",    rd_cnt, 0);

        // INCR4 write, ERROR on beat 1 data phase
        run_cmd(1'b1, 32'h200, HBURST_INCR4, 5'd0, 1000, 0, 3, 1000, 0);
        check_val("t6_pre_err",   tr_log[2], HTRANS_SEQ);
        check_val("t6_err_idle",  tr_log[3], HTRANS_IDLE);
        check_val("t6_err2_idle", tr_log[4], HTRANS_IDLE);
        check_val("t6_done_rel",  done_rel, 5);
        check_val("t6_done_err",  done_err_seen, 1'b1);
        check_val("t6_wr_cnt",    wr_cnt, 2);

        // INCR with len 0 clamps to one beat
        run_cmd(1'b0, 32'h10, HBURST_INCR, 5'd0, 1000, 0, 1000, 1000, 0);
        check_val("t7_nonseq",    tr_log[1], HTRANS_NONSEQ);
        check_val("t7_idle",      tr_log[2], HTRANS_IDLE);
        check_val("t7_done_rel",  done_rel, 3);

        // INCR with len 20 clamps to sixteen beats
        run_cmd(1'b0, 32'h0, HBURST_INCR, 5'd20, 1000, 0, 1000, 1000, 0);
        check_val("t8_last_tr",   tr_log[16], HTRANS_SEQ);
        check_val("t8_last_a",    ad_log[16], 32'h3C);
        check_val("t8_idle",      tr_log[17], HTRANS_IDLE);
        check_val("t8_rd_cnt",    rd_cnt, 16);
        check_val("t8_done_rel",  done_rel, 18);

        // Reset in the middle of a burst abandons it silently
        @(posedge hclk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_burst = HBURST_INCR4;
        @(posedge hclk); #1;
        cmd_valid = 1'b0;
        @(posedge hclk); #1;
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        dn = 0;
        repeat (6) begin
            @(negedge hclk);
            if (done) dn = dn + 1;
        end
        check_val("t9_no_done",   dn, 0);
        check_val("t9_htrans",    bus.htrans, HTRANS_IDLE);
        check_val("t9_cmd_rdy",   cmd_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
